// File: rtl/uart_loader_if.sv
// uart_loader_if: receive-byte handshake and instruction-memory write bus
// between the UART receiver, the program loader and instruction memory.
interface uart_loader_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 8
);
  logic                  packet_ready;
  logic [7:0]            uart_packet;
  logic                  packet_ack;
  logic                  imem_we;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [DATA_WIDTH-1:0] imem_wdata;

  // Loader side: consumes bytes, drives the memory write port.
  modport master (
    input  packet_ready, uart_packet,
    output packet_ack, imem_we, imem_addr, imem_wdata
  );

  // Environment side: byte source and memory sink.
  modport slave (
    output packet_ready, uart_packet,
    input  packet_ack, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/uart_loader.sv
// uart_loader: parses framed load records (SYNC 0xA5, COUNT, words MSB
// first, optional CHK) from the UART receiver and streams the assembled
// words into instruction memory while the core is halted.
// Optional feature macro: UART_LOADER_CHECKSUM_EN (frame carries a CHK
// byte that is verified against the 8-bit sum of COUNT and data bytes).
module uart_loader #(
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          HALT_flag,
  uart_loader_if.master bus,
  output logic          load_done,
  output logic          load_error,
  output logic [1:0]    err_code
);
  localparam int unsigned BYTES = DATA_WIDTH / 8;
  localparam int unsigned BW    = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int unsigned TW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [2:0] {S_IDLE, S_COUNT, S_DATA, S_WRITE, S_CHK} state_t;

  state_t                state_q, state_d;
  logic                  ack_q, ack_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic [1:0]            err_q, err_d;
  logic [7:0]            remain_q, remain_d;
  logic [7:0]            chk_q, chk_d;
  logic [BW-1:0]         bytes_q, bytes_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic                  consume;
  logic                  tmo_hit;
  logic [7:0]            rx_byte;

  assign rx_byte = bus.uart_packet;
  // The registered ack blocks a second consume of the same byte.
  assign consume = HALT_flag && bus.packet_ready && !ack_q;

  // Next-state, datapath and output computation for the frame parser.
  always_comb begin
    state_d  = state_q;
    ack_d    = consume;
    we_d     = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    word_d   = word_q;
    done_d   = 1'b0;
    error_d  = 1'b0;
    err_d    = err_q;
    remain_d = remain_q;
    chk_d    = chk_q;
    bytes_d  = bytes_q;
    tmo_d    = '0;
    tmo_hit  = 1'b0;

    // Inter-byte watchdog runs only while waiting on a byte inside a frame;
    // a byte on the firing edge wins.
    if (state_q == S_COUNT || state_q == S_DATA || state_q == S_CHK) begin
      if (consume) begin
        tmo_d = '0;
      end else begin
        tmo_d   = tmo_q + 1'b1;
        tmo_hit = (tmo_q == TW'(TIMEOUT_CYCLES - 1));
      end
    end else if (state_q == S_WRITE) begin
      tmo_d = tmo_q;
    end

    case (state_q)
      S_IDLE: begin
        if (consume && rx_byte == 8'hA5) begin
          state_d = S_COUNT;
          err_d   = 2'b00;
          addr_d  = '0;
        end
      end
      S_COUNT: begin
        if (consume) begin
          remain_d = rx_byte;
          chk_d    = rx_byte;
          bytes_d  = '0;
          word_d   = '0;
          if (rx_byte == 8'h00) begin
`ifdef UART_LOADER_CHECKSUM_EN
            state_d = S_CHK;
`else
            state_d = S_IDLE;
            done_d  = 1'b1;
`endif
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (consume) begin
          word_d = (word_q << 8) | DATA_WIDTH'(rx_byte);
          chk_d  = chk_q + rx_byte;
          if (bytes_q == BW'(BYTES - 1)) begin
            bytes_d = '0;
            we_d    = 1'b1;
            wdata_d = word_d;
            state_d = S_WRITE;
          end else begin
            bytes_d = bytes_q + 1'b1;
          end
        end
      end
      S_WRITE: begin
        addr_d   = addr_q + 1'b1;
        remain_d = remain_q - 1'b1;
        if (remain_q == 8'd1) begin
`ifdef UART_LOADER_CHECKSUM_EN
          state_d = S_CHK;
`else
          state_d = S_IDLE;
          done_d  = 1'b1;
`endif
        end else begin
          state_d = S_DATA;
        end
      end
      S_CHK: begin
        if (consume) begin
          state_d = S_IDLE;
          if (rx_byte == chk_q) begin
            done_d = 1'b1;
          end else begin
            error_d = 1'b1;
            err_d   = 2'b01;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (tmo_hit) begin
      state_d = S_IDLE;
      error_d = 1'b1;
      err_d   = 2'b10;
      tmo_d   = '0;
    end

    // Leaving HALT acts as a reset that keeps the last error code visible.
    if (!HALT_flag) begin
      state_d  = S_IDLE;
      ack_d    = 1'b0;
      we_d     = 1'b0;
      addr_d   = '0;
      wdata_d  = '0;
      word_d   = '0;
      done_d   = 1'b0;
      error_d  = 1'b0;
      err_d    = err_q;
      remain_d = '0;
      chk_d    = '0;
      bytes_d  = '0;
      tmo_d    = '0;
    end
  end

  // State and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      ack_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      word_q   <= '0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      err_q    <= 2'b00;
      remain_q <= '0;
      chk_q    <= '0;
      bytes_q  <= '0;
      tmo_q    <= '0;
    end else begin
      state_q  <= state_d;
      ack_q    <= ack_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      word_q   <= word_d;
      done_q   <= done_d;
      error_q  <= error_d;
      err_q    <= err_d;
      remain_q <= remain_d;
      chk_q    <= chk_d;
      bytes_q  <= bytes_d;
      tmo_q    <= tmo_d;
    end
  end

  assign bus.packet_ack = ack_q;
  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign load_done      = done_q;
  assign load_error     = error_q;
  assign err_code       = err_q;
endmodule
